// File: rtl/riscv_types.sv
// Shared RV32I core types: Wishbone arbiter state encoding, fetch NOP default
// and byte-lane select patterns.
package riscv_types;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DATA  = 2'd1,
        FETCH = 2'd2
    } wb_arb_state_t;

    localparam logic [31:0] NOP_INSN_DEFAULT = 32'h0000_0013;

    localparam logic [3:0] WB_SEL_BYTE = 4'b0001;
    localparam logic [3:0] WB_SEL_HALF = 4'b0011;
    localparam logic [3:0] WB_SEL_WORD = 4'b1111;

endpackage

// File: rtl/wb_lane_gen.sv
// Byte-lane select and replicated write data for MEM-stage accesses,
// derived from funct3 size bits and the low address bits.
module wb_lane_gen
    import riscv_types::*;
(
    input  logic [1:0]  op,
    input  logic [1:0]  addr,
    input  logic [31:0] wdata,
    output logic [3:0]  sel,
    output logic [31:0] dat
);

    always_comb begin
        sel = WB_SEL_WORD;
        dat = wdata;
        case (op)
            2'b00: begin
                sel = WB_SEL_BYTE << addr;
                dat = {4{wdata[7:0]}};
            end
            2'b01: begin
                sel = WB_SEL_HALF << {addr[1], 1'b0};
                dat = {2{wdata[15:0]}};
            end
            default: begin
                sel = WB_SEL_WORD;
                dat = wdata;
            end
        endcase
    end

endmodule

// File: rtl/wb_core_arbiter.sv
// Wishbone B4 classic arbiter sharing one master port between instruction fetch
// and MEM-stage data access. Optional watchdog enabled by defining WB_TIMEOUT_EN.
module wb_core_arbiter
    import riscv_types::*;
#(
    parameter int          TIMEOUT_CYCLES = 255,
    parameter logic [31:0] NOP_INSN       = NOP_INSN_DEFAULT
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] if_addr,
    input  logic        if_req,
    output logic [31:0] if_rdata,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [2:0]  d_op,
    input  logic        d_re,
    input  logic        d_we,
    output logic [31:0] d_rdata,
    output logic        stall_pipl,
    output logic        bus_err,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i
);

    wb_arb_state_t state, state_next;

    logic        d_need, i_need, d_pend, i_pend;
    logic        d_done, i_done;
    logic        done_evt, err_evt, timeout;
    logic        start_data, start_fetch, end_bus, d_complete, i_complete;
    logic [3:0]  lane_sel;
    logic [31:0] lane_dat;
    logic        unused_ok;

    assign unused_ok = &{1'b0, d_op[2], if_addr[1:0]};

    assign d_need     = d_re | d_we;
    assign i_need     = if_req;
    assign d_pend     = d_need & ~d_done;
    assign i_pend     = i_need & ~i_done;
    assign stall_pipl = d_pend | i_pend;

    wb_lane_gen u_lane_gen (
        .op    (d_op[1:0]),
        .addr  (d_addr[1:0]),
        .wdata (d_wdata),
        .sel   (lane_sel),
        .dat   (lane_dat)
    );

`ifdef WB_TIMEOUT_EN
    logic [7:0] wdog;

    assign timeout = (state != IDLE) && (wdog == 8'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wdog <= '0;
        end else if (start_data || start_fetch) begin
            wdog <= '0;
        end else if (wb_cyc_o) begin
            wdog <= wdog + 8'd1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    // A watchdog expiry is treated exactly like a slave error.
    assign done_evt = wb_ack_i | wb_err_i | timeout;
    assign err_evt  = wb_err_i | timeout;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Data goes first: it belongs to the older instruction in the pipeline.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (d_pend) begin
                    state_next = DATA;
                end else if (i_pend) begin
                    state_next = FETCH;
                end
            end
            DATA: begin
                if (done_evt) begin
                    state_next = i_pend ? FETCH : IDLE;
                end
            end
            FETCH: begin
                if (done_evt) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        start_data  = (state == IDLE) && (state_next == DATA);
        start_fetch = (state != FETCH) && (state_next == FETCH);
        end_bus     = (state != IDLE) && (state_next == IDLE);
        d_complete  = (state == DATA) && done_evt;
        i_complete  = (state == FETCH) && done_evt;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            d_done <= 1'b0;
            i_done <= 1'b0;
        end else if (!stall_pipl) begin
            d_done <= 1'b0;
            i_done <= 1'b0;
        end else begin
            if (d_complete) d_done <= 1'b1;
            if (i_complete) i_done <= 1'b1;
        end
    end

    // Back-to-back data->fetch keeps cyc/stb high and only swaps adr/sel/we.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_we_o  <= 1'b0;
            wb_adr_o <= '0;
            wb_sel_o <= '0;
            wb_dat_o <= '0;
        end else if (start_data) begin
            wb_cyc_o <= 1'b1;
            wb_stb_o <= 1'b1;
            wb_we_o  <= d_we;
            wb_adr_o <= {d_addr[31:2], 2'b00};
            wb_sel_o <= lane_sel;
            wb_dat_o <= lane_dat;
        end else if (start_fetch) begin
            wb_cyc_o <= 1'b1;
            wb_stb_o <= 1'b1;
            wb_we_o  <= 1'b0;
            wb_adr_o <= {if_addr[31:2], 2'b00};
            wb_sel_o <= WB_SEL_WORD;
        end else if (end_bus) begin
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_we_o  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            if_rdata <= NOP_INSN;
            d_rdata  <= '0;
            bus_err  <= 1'b0;
        end else begin
            if (d_complete) d_rdata <= err_evt ? 32'h0 : wb_dat_i;
            if (i_complete) if_rdata <= err_evt ? NOP_INSN : wb_dat_i;
            if ((d_complete || i_complete) && err_evt) bus_err <= 1'b1;
        end
    end

endmodule
